// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared state encoding, default sizes and tally-width helper for the vote collector
package vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPEN,
        ST_TALLY,
        ST_DONE
    } vote_state_e;

    localparam int N_VOTERS_DEF = 5;
    localparam int THRESH_DEF   = 3;

    // Tally must hold the value N (everyone voted yes), hence n+1 codes.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vote_tally_seq.sv
// rtl/vote_tally_seq.sv - serial tally: scans one input bit per cycle and accumulates the ones
module vote_tally_seq #(
    parameter int N_BITS = 5,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [N_BITS-1:0] bits_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [CNT_W-1:0]  count_next_o,
    output logic              last_o
);
    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    logic             run_q, run_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        run_d        = run_q;
        idx_d        = idx_q;
        count_d      = count_q;
        count_next_o = count_q + CNT_W'(bits_i[idx_q]);
        last_o       = run_q && (idx_q == IDX_W'(N_BITS - 1));
        if (clear_i || start_i) begin
            run_d   = start_i;
            idx_d   = '0;
            count_d = '0;
        end else if (run_q) begin
            count_d = count_next_o;
            idx_d   = idx_q + IDX_W'(1);
            if (last_o) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            run_q   <= run_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vote_collector.sv
// rtl/vote_collector.sv - ballot front-end: collects one vote per voter, tallies serially, publishes result
module vote_collector
    import vote_pkg::*;
#(
    parameter int N_VOTERS    = N_VOTERS_DEF,
    parameter int ID_W        = 3,
    parameter int CNT_W       = cnt_width(N_VOTERS),
    parameter int THRESH      = THRESH_DEF,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                close_i,
    input  logic                vote_valid_i,
    output logic                vote_ready_o,
    input  logic [ID_W-1:0]     vote_id_i,
    input  logic                vote_val_i,
    output logic [N_VOTERS-1:0] ballot_o,
    output logic [N_VOTERS-1:0] voted_o,
    output logic [CNT_W-1:0]    count_o,
    output logic                result_o,
    output logic                done_o,
    output logic                busy_o,
    output logic                err_dup_o,
    output logic                err_id_o
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 2);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    vote_state_e         state_q, state_d;
    logic [N_VOTERS-1:0] ballot_q, ballot_d;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic                result_q, result_d;
    logic                err_dup_q, err_dup_d;
    logic                err_id_q, err_id_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                tally_clear, tally_start, tally_last;
    logic [CNT_W-1:0]    tally_count, tally_next;
    logic                timeout_hit;

    assign timeout_hit = (TIMEOUT_CYC != 0) && (to_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        ballot_d    = ballot_q;
        voted_d     = voted_q;
        result_d    = result_q;
        to_d        = to_q;
        err_dup_d   = 1'b0;
        err_id_d    = 1'b0;
        tally_clear = 1'b0;
        tally_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_OPEN;
                    ballot_d    = '0;
                    voted_d     = '0;
                    result_d    = 1'b0;
                    to_d        = '0;
                    tally_clear = 1'b1;
                end
            end
            ST_OPEN: begin
                to_d = (&to_q) ? to_q : to_q + TO_W'(1);
                if (vote_valid_i) begin
                    if (int'(vote_id_i) >= N_VOTERS) begin
                        err_id_d = 1'b1;
                    end else if (voted_q[vote_id_i]) begin
                        err_dup_d = 1'b1;
                    end else begin
                        voted_d[vote_id_i]  = 1'b1;
                        ballot_d[vote_id_i] = vote_val_i;
                    end
                end
                // voted_d already includes this cycle's vote, so it is recorded before closing.
                if (close_i || (&voted_d) || timeout_hit) begin
                    state_d     = ST_TALLY;
                    tally_start = 1'b1;
                end
            end
            ST_TALLY: begin
                if (tally_last) begin
                    state_d  = ST_DONE;
                    result_d = int'(tally_next) >= THRESH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ballot_q  <= '0;
            voted_q   <= '0;
            result_q  <= 1'b0;
            err_dup_q <= 1'b0;
            err_id_q  <= 1'b0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            ballot_q  <= ballot_d;
            voted_q   <= voted_d;
            result_q  <= result_d;
            err_dup_q <= err_dup_d;
            err_id_q  <= err_id_d;
            to_q      <= to_d;
        end
    end

    vote_tally_seq #(
        .N_BITS (N_VOTERS),
        .CNT_W  (CNT_W)
    ) u_tally (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (tally_clear),
        .start_i      (tally_start),
        .bits_i       (ballot_q),
        .count_o      (tally_count),
        .count_next_o (tally_next),
        .last_o       (tally_last)
    );

    assign vote_ready_o = (state_q == ST_OPEN);
    assign busy_o       = (state_q == ST_OPEN) || (state_q == ST_TALLY);
    assign done_o       = (state_q == ST_DONE);
    assign ballot_o     = ballot_q;
    assign voted_o      = voted_q;
    assign count_o      = tally_count;
    assign result_o     = result_q;
    assign err_dup_o    = err_dup_q;
    assign err_id_o     = err_id_q;

endmodule

// File: tb/tb_vote_collector.sv
// tb/tb_vote_collector.sv - randomized and directed self-checking bench for vote_collector
module tb_vote_collector;
    localparam int N  = 5;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i, close_i, vote_valid_i, vote_val_i;
    logic [2:0] vote_id_i;
    logic       vote_ready_o, result_o, done_o, busy_o, err_dup_o, err_id_o;
    logic [4:0] ballot_o, voted_o;
    logic [2:0] count_o;

    int errors = 0;
    int checks = 0;

    logic [4:0] m_ballot, m_voted;
    int         open_cyc;
    bit         closed;

    vote_collector #(
        .N_VOTERS    (N),
        .ID_W        (3),
        .CNT_W       (3),
        .THRESH      (3),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .close_i      (close_i),
        .vote_valid_i (vote_valid_i),
        .vote_ready_o (vote_ready_o),
        .vote_id_i    (vote_id_i),
        .vote_val_i   (vote_val_i),
        .ballot_o     (ballot_o),
        .voted_o      (voted_o),
        .count_o      (count_o),
        .result_o     (result_o),
        .done_o       (done_o),
        .busy_o       (busy_o),
        .err_dup_o    (err_dup_o),
        .err_id_o     (err_id_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic open_session();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_open", busy_o, 1);
        check("ready_open", vote_ready_o, 1);
        check("ballot_clr", ballot_o, 0);
        check("voted_clr", voted_o, 0);
        check("count_clr", count_o, 0);
        m_ballot = '0;
        m_voted  = '0;
        open_cyc = 0;
        closed   = 1'b0;
    endtask

    // One OPEN cycle: drive, update the reference ballot, then check the cycle after.
    task automatic step(input bit v, input logic [2:0] id, input bit val, input bit cl);
        bit e_id, e_dup;
        e_id  = 1'b0;
        e_dup = 1'b0;
        vote_valid_i = v;
        vote_id_i    = id;
        vote_val_i   = val;
        close_i      = cl;
        if (v) begin
            if (id >= 3'(N)) e_id = 1'b1;
            else if (m_voted[id]) e_dup = 1'b1;
            else begin
                m_voted[id]  = 1'b1;
                m_ballot[id] = val;
            end
        end
        if (cl || m_voted == 5'h1f || open_cyc == TO - 1) closed = 1'b1;
        open_cyc++;
        @(negedge clk);
        vote_valid_i = 1'b0;
        close_i      = 1'b0;
        check("err_id", err_id_o, e_id);
        check("err_dup", err_dup_o, e_dup);
        check("voted", voted_o, m_voted);
        check("ballot", ballot_o, m_ballot);
        check("ready", vote_ready_o, !closed);
    endtask

    task automatic finish_session();
        int exp_cnt;
        exp_cnt = $countones(m_ballot);
        for (int k = 0; k < N; k++) begin
            check("done_early", done_o, 0);
            check("busy_tally", busy_o, 1);
            @(negedge clk);
        end
        check("done_pulse", done_o, 1);
        check("count", count_o, exp_cnt);
        check("result", result_o, exp_cnt >= 3);
        check("ballot_fin", ballot_o, m_ballot);
        check("voted_fin", voted_o, m_voted);
        @(negedge clk);
        check("done_once", done_o, 0);
        check("busy_idle", busy_o, 0);
        check("count_hold", count_o, exp_cnt);
        check("result_hold", result_o, exp_cnt >= 3);
        check("ballot_hold", ballot_o, m_ballot);
    endtask

    task automatic random_session();
        open_session();
        while (!closed) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 15) == 0);
        end
        finish_session();
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; close_i = 1'b0;
        vote_valid_i = 1'b0; vote_id_i = '0; vote_val_i = 1'b0;
        m_ballot = '0; m_voted = '0; open_cyc = 0; closed = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ready", vote_ready_o, 0);
        check("rst_ballot", ballot_o, 0);
        check("rst_count", count_o, 0);
        rst_n = 1'b1;

        // all voted: 0,1,2 yes, 3,4 no
        open_session();
        step(1, 0, 1, 0); step(1, 1, 1, 0); step(1, 2, 1, 0); step(1, 3, 0, 0); step(1, 4, 0, 0);
        check("autoclose", closed, 1);
        finish_session();

        // ids 1 and 3 yes, then close
        open_session();
        step(1, 1, 1, 0); step(1, 3, 1, 0); step(0, 0, 0, 1);
        finish_session();

        // duplicate id 2, bad id 6, vote accepted together with close
        open_session();
        step(1, 2, 1, 0); step(1, 2, 0, 0); step(1, 6, 1, 0); step(1, 0, 1, 1);
        finish_session();

        // timeout with no votes; start_i while OPEN must be ignored
        open_session();
        start_i = 1'b1;
        while (!closed) step(0, 0, 0, 0);
        start_i = 1'b0;
        check("timeout_cyc", open_cyc, TO);
        finish_session();

        // reset in the middle of TALLY
        open_session();
        step(1, 0, 1, 0); step(1, 1, 1, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_t_busy", busy_o, 0);
        check("rst_t_done", done_o, 0);
        check("rst_t_ballot", ballot_o, 0);
        check("rst_t_voted", voted_o, 0);
        check("rst_t_count", count_o, 0);
        check("rst_t_result", result_o, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rst_no_done", done_o, 0);
        end
        open_session();
        step(1, 4, 1, 0); step(1, 2, 1, 0); step(1, 0, 1, 0); step(0, 0, 0, 1);
        finish_session();

        for (int s = 0; s < 30; s++) random_session();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
